proc_sequencer: RTL and testbench

- Parametrised successor to the single-cycle-decode processor controller.
- Owns the instruction register, the timestep counter and the fetch handshake internally, so no external IRin/Clr loop is needed.
- Decodes the ld/cp/ALU/addi/subi ISA into per-cycle datapath strobes for the register file, the A/G ALU latches, the immediate driver and the external-data driver.
- Sits between the instruction source and the shared-bus datapath.

---
 rtl/proc_seq_pkg.sv | 37 +++
 rtl/proc_seq_decode.sv | 109 ++++++++++
 rtl/proc_sequencer.sv | 144 ++++++++++++++
 tb/tb_proc_sequencer.sv | 305 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/proc_seq_pkg.sv
// Shared constants for the processor sequencer: FSM state encodings,
// register-class opcodes, instruction suffixes and ALU operation codes.
package proc_seq_pkg;

  // FSM state encodings: FETCH accepts a word, EXEC runs its steps
  localparam logic [0:0] FETCH = 1'b0;
  localparam logic [0:0] EXEC  = 1'b1;

  // Register-class opcodes held in IR[5:2] when the suffix is SUF_REG
  localparam logic [3:0] OP_LD  = 4'h0;
  localparam logic [3:0] OP_CP  = 4'h1;
  localparam logic [3:0] OP_ADD = 4'h2;
  localparam logic [3:0] OP_SUB = 4'h3;
  localparam logic [3:0] OP_INV = 4'h4;
  localparam logic [3:0] OP_FLP = 4'h5;
  localparam logic [3:0] OP_AND = 4'h6;
  localparam logic [3:0] OP_OR  = 4'h7;
  localparam logic [3:0] OP_XOR = 4'h8;
  localparam logic [3:0] OP_LSL = 4'h9;
  localparam logic [3:0] OP_LSR = 4'hA;
  localparam logic [3:0] OP_ASR = 4'hB;

  // Instruction suffixes in IR[1:0]; 2'b10 is unassigned
  localparam logic [1:0] SUF_REG  = 2'b00;
  localparam logic [1:0] SUF_ADDI = 2'b01;
  localparam logic [1:0] SUF_SUBI = 2'b11;

  // ALU codes used by the immediate forms
  localparam logic [3:0] ALU_ADD = 4'd2;
  localparam logic [3:0] ALU_SUB = 4'd3;

  // True for register-class opcodes that run through the three-step ALU sequence
  function automatic logic is_alu_reg_op(input logic [3:0] opc);
    return (opc >= OP_ADD) && (opc <= OP_ASR);
  endfunction

endpackage

// File: rtl/proc_seq_decode.sv
// Combinational decoder: maps (IR, step, ext_valid) onto the datapath
// strobes for the current EXEC cycle, plus flags telling the sequencer
// whether this is the final cycle (last) or the step counter should move
// on (advance). Unused addresses, imm and alu_op are held at zero.
module proc_seq_decode
  import proc_seq_pkg::*;
#(
  parameter int DATA_W = 10,
  parameter int RA_W   = 2
) (
  input  logic [DATA_W-1:0] ir,
  input  logic [1:0]        step,
  input  logic              ext_valid,
  output logic [RA_W-1:0]   rin,
  output logic [RA_W-1:0]   rout,
  output logic              enw,
  output logic              enr,
  output logic              ain,
  output logic              gin,
  output logic              gout,
  output logic              ext,
  output logic              imm_oe,
  output logic [DATA_W-1:0] imm,
  output logic [3:0]        alu_op,
  output logic              illegal,
  output logic              last,
  output logic              advance
);

  logic [RA_W-1:0]   rx;
  logic [RA_W-1:0]   ry;
  logic [1:0]        suffix;
  logic [3:0]        opc;
  logic [DATA_W-1:0] imm_val;

  assign rx      = ir[DATA_W-1 -: RA_W];
  assign ry      = ir[DATA_W-RA_W-1 -: RA_W];
  assign suffix  = ir[1:0];
  assign opc     = ir[5:2];
  assign imm_val = DATA_W'(ir[DATA_W-RA_W-1:2]);

  // Per-class, per-step strobe table; ld holds its strobes off until ext_valid
  always_comb begin
    rin     = '0;
    rout    = '0;
    enw     = 1'b0;
    enr     = 1'b0;
    ain     = 1'b0;
    gin     = 1'b0;
    gout    = 1'b0;
    ext     = 1'b0;
    imm_oe  = 1'b0;
    imm     = '0;
    alu_op  = '0;
    illegal = 1'b0;
    last    = 1'b0;
    advance = 1'b0;
    if (suffix == SUF_REG && opc == OP_LD) begin
      if (ext_valid) begin
        ext  = 1'b1;
        enw  = 1'b1;
        rin  = rx;
        last = 1'b1;
      end
    end else if (suffix == SUF_REG && opc == OP_CP) begin
      enr  = 1'b1;
      rout = ry;
      enw  = 1'b1;
      rin  = rx;
      last = 1'b1;
    end else if ((suffix == SUF_REG && is_alu_reg_op(opc)) ||
                 suffix == SUF_ADDI || suffix == SUF_SUBI) begin
      case (step)
        2'd0: begin
          enr     = 1'b1;
          rout    = rx;
          ain     = 1'b1;
          advance = 1'b1;
        end
        2'd1: begin
          gin     = 1'b1;
          advance = 1'b1;
          if (suffix == SUF_REG) begin
            enr    = 1'b1;
            rout   = ry;
            alu_op = opc;
          end else begin
            imm_oe = 1'b1;
            imm    = imm_val;
            alu_op = (suffix == SUF_ADDI) ? ALU_ADD : ALU_SUB;
          end
        end
        2'd2: begin
          gout = 1'b1;
          enw  = 1'b1;
          rin  = rx;
          last = 1'b1;
        end
        default: begin
          last = 1'b1;
        end
      endcase
    end else begin
      illegal = 1'b1;
      last    = 1'b1;
    end
  end

endmodule

// File: rtl/proc_sequencer.sv
// Processor sequencer: owns the instruction register, the step counter and
// the fetch handshake, and gates the decoder's strobes onto the datapath
// while an instruction is in flight.
// Optional feature: define PROC_SEQ_PERF_EN to add the instr_count port,
// a CNT_W-bit wrapping count of retired instructions (illegal included).
module proc_sequencer
  import proc_seq_pkg::*;
#(
  parameter int DATA_W = 10,
  parameter int RA_W   = 2,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] instr,
  input  logic              instr_valid,
  output logic              instr_ready,
  input  logic              ext_valid,
  output logic [RA_W-1:0]   rin,
  output logic [RA_W-1:0]   rout,
  output logic              enw,
  output logic              enr,
  output logic              ain,
  output logic              gin,
  output logic              gout,
  output logic              ext,
  output logic              imm_oe,
  output logic [DATA_W-1:0] imm,
  output logic [3:0]        alu_op,
  output logic              busy,
  output logic              done,
  output logic              illegal
`ifdef PROC_SEQ_PERF_EN
  ,
  output logic [CNT_W-1:0]  instr_count
`endif
);

  // The field layout only works when Rx, Ry and the 6-bit op fill the word
  if (DATA_W != 2*RA_W + 6 || CNT_W < 1) begin : g_bad_cfg
    $error("proc_sequencer: DATA_W must equal 2*RA_W+6 and CNT_W must be positive");
  end

  logic [0:0]        state;
  logic [DATA_W-1:0] ir;
  logic [1:0]        step;

  logic [RA_W-1:0]   dec_rin;
  logic [RA_W-1:0]   dec_rout;
  logic              dec_enw;
  logic              dec_enr;
  logic              dec_ain;
  logic              dec_gin;
  logic              dec_gout;
  logic              dec_ext;
  logic              dec_imm_oe;
  logic [DATA_W-1:0] dec_imm;
  logic [3:0]        dec_alu_op;
  logic              dec_illegal;
  logic              dec_last;
  logic              dec_advance;

  proc_seq_decode #(
    .DATA_W(DATA_W),
    .RA_W  (RA_W)
  ) u_decode (
    .ir       (ir),
    .step     (step),
    .ext_valid(ext_valid),
    .rin      (dec_rin),
    .rout     (dec_rout),
    .enw      (dec_enw),
    .enr      (dec_enr),
    .ain      (dec_ain),
    .gin      (dec_gin),
    .gout     (dec_gout),
    .ext      (dec_ext),
    .imm_oe   (dec_imm_oe),
    .imm      (dec_imm),
    .alu_op   (dec_alu_op),
    .illegal  (dec_illegal),
    .last     (dec_last),
    .advance  (dec_advance)
  );

  assign busy        = (state == EXEC);
  assign instr_ready = (state == FETCH) && !reset;
  assign done        = busy && dec_last;

  // Strobes are only driven in EXEC, so FETCH and reset present an idle datapath
  always_comb begin
    rin     = busy ? dec_rin    : '0;
    rout    = busy ? dec_rout   : '0;
    enw     = busy && dec_enw;
    enr     = busy && dec_enr;
    ain     = busy && dec_ain;
    gin     = busy && dec_gin;
    gout    = busy && dec_gout;
    ext     = busy && dec_ext;
    imm_oe  = busy && dec_imm_oe;
    imm     = busy ? dec_imm    : '0;
    alu_op  = busy ? dec_alu_op : '0;
    illegal = busy && dec_illegal;
  end

  // Fetch handshake, instruction capture and step sequencing
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= FETCH;
      ir    <= '0;
      step  <= '0;
    end else begin
      case (state)
        FETCH: begin
          if (instr_valid) begin
            ir    <= instr;
            step  <= '0;
            state <= EXEC;
          end
        end
        default: begin
          if (dec_last) begin
            step  <= '0;
            state <= FETCH;
          end else if (dec_advance) begin
            step <= step + 2'd1;
          end
        end
      endcase
    end
  end

`ifdef PROC_SEQ_PERF_EN
  // Retired-instruction counter, wraps naturally at 2^CNT_W
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      instr_count <= '0;
    end else if (done) begin
      instr_count <= instr_count + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_proc_sequencer.sv
// Scoreboard bench for proc_sequencer: each instruction pushes its expected
// per-cycle output vectors (fetch cycle plus EXEC cycles) into a queue, and
// each clock the observed outputs are popped against the head of the queue.
module tb_proc_sequencer;

`ifdef PROC_SEQ_PERF_EN
  localparam int CNT_W_TB = 2;
`else
  localparam int CNT_W_TB = 16;
`endif

  typedef struct packed {
    logic       ready;
    logic       busy;
    logic       done;
    logic       illegal;
    logic       enw;
    logic       enr;
    logic       ain;
    logic       gin;
    logic       gout;
    logic       ext;
    logic       imm_oe;
    logic [1:0] rin;
    logic [1:0] rout;
    logic [3:0] alu_op;
    logic [9:0] imm;
  } obs_t;

  logic       clk;
  logic       reset;
  logic [9:0] instr;
  logic       instr_valid;
  logic       instr_ready;
  logic       ext_valid;
  logic [1:0] rin;
  logic [1:0] rout;
  logic       enw;
  logic       enr;
  logic       ain;
  logic       gin;
  logic       gout;
  logic       ext;
  logic       imm_oe;
  logic [9:0] imm;
  logic [3:0] alu_op;
  logic       busy;
  logic       done;
  logic       illegal;
`ifdef PROC_SEQ_PERF_EN
  logic [CNT_W_TB-1:0] instr_count;
`endif

  int   checks;
  int   failures;
  int   exp_cnt;
  obs_t exp_q[$];

  proc_sequencer #(
    .DATA_W(10),
    .RA_W  (2),
    .CNT_W (CNT_W_TB)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .instr      (instr),
    .instr_valid(instr_valid),
    .instr_ready(instr_ready),
    .ext_valid  (ext_valid),
    .rin        (rin),
    .rout       (rout),
    .enw        (enw),
    .enr        (enr),
    .ain        (ain),
    .gin        (gin),
    .gout       (gout),
    .ext        (ext),
    .imm_oe     (imm_oe),
    .imm        (imm),
    .alu_op     (alu_op),
    .busy       (busy),
    .done       (done),
    .illegal    (illegal)
`ifdef PROC_SEQ_PERF_EN
    ,
    .instr_count(instr_count)
`endif
  );

  // Free-running clock
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Hard stop in case something upstream never returns
  initial begin
    #500000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] watchdog");
  end

  task automatic check_output(input string tag, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      failures++;
      $display("[TB] FAIL %s got=%h expected=%h", tag, got, want);
    end
  endtask

  function automatic obs_t sample_outputs();
    obs_t o;
    o.ready   = instr_ready;
    o.busy    = busy;
    o.done    = done;
    o.illegal = illegal;
    o.enw     = enw;
    o.enr     = enr;
    o.ain     = ain;
    o.gin     = gin;
    o.gout    = gout;
    o.ext     = ext;
    o.imm_oe  = imm_oe;
    o.rin     = rin;
    o.rout    = rout;
    o.alu_op  = alu_op;
    o.imm     = imm;
    return o;
  endfunction

  task automatic check_count(input string tag);
`ifdef PROC_SEQ_PERF_EN
    check_output(tag, 32'(instr_count), 32'(exp_cnt % (1 << CNT_W_TB)));
`else
    if (tag.len() < 0) $display("[TB] %s", tag);
`endif
  endtask

  function automatic logic is_ld(input logic [9:0] w);
    return (w[1:0] == 2'b00) && (w[5:2] == 4'h0);
  endfunction

  // Expected cycle-by-cycle outputs for one instruction, from the ISA description
  task automatic push_expected(input logic [9:0] w, input int stall);
    obs_t       f;
    obs_t       e;
    logic [1:0] rx;
    logic [1:0] ry;
    logic [1:0] suf;
    logic [3:0] opc;
    rx  = w[9:8];
    ry  = w[7:6];
    suf = w[1:0];
    opc = w[5:2];
    f = '0;
    f.ready = 1'b1;
    exp_q.push_back(f);
    e = '0;
    e.busy = 1'b1;
    if (suf == 2'b10 || (suf == 2'b00 && opc >= 4'hC)) begin
      e.illegal = 1'b1;
      e.done    = 1'b1;
      exp_q.push_back(e);
    end else if (suf == 2'b00 && opc == 4'h0) begin
      for (int i = 0; i < stall; i++) exp_q.push_back(e);
      e.ext  = 1'b1;
      e.enw  = 1'b1;
      e.rin  = rx;
      e.done = 1'b1;
      exp_q.push_back(e);
    end else if (suf == 2'b00 && opc == 4'h1) begin
      e.enr  = 1'b1;
      e.rout = ry;
      e.enw  = 1'b1;
      e.rin  = rx;
      e.done = 1'b1;
      exp_q.push_back(e);
    end else begin
      e.enr  = 1'b1;
      e.rout = rx;
      e.ain  = 1'b1;
      exp_q.push_back(e);
      e = '0;
      e.busy = 1'b1;
      e.gin  = 1'b1;
      if (suf == 2'b00) begin
        e.enr    = 1'b1;
        e.rout   = ry;
        e.alu_op = opc;
      end else begin
        e.imm_oe = 1'b1;
        e.imm    = {4'b0000, w[7:2]};
        e.alu_op = (suf == 2'b01) ? 4'd2 : 4'd3;
      end
      exp_q.push_back(e);
      e = '0;
      e.busy = 1'b1;
      e.gout = 1'b1;
      e.enw  = 1'b1;
      e.rin  = rx;
      e.done = 1'b1;
      exp_q.push_back(e);
    end
  endtask

  // Drive one instruction through fetch and EXEC; abort_at >= 0 pulses reset after that cycle
  task automatic apply_stimulus(input string name, input logic [9:0] w, input int stall,
                                input int abort_at);
    obs_t e;
    obs_t o;
    int   k;
    push_expected(w, stall);
    k = 0;
    while (exp_q.size() > 0) begin
      @(negedge clk);
      instr_valid = (k == 0);
      instr       = (k == 0) ? w : 10'($urandom);
      if (is_ld(w) && k > 0) ext_valid = (k - 1 >= stall);
      else                   ext_valid = 1'($urandom);
      #1;
      e = exp_q.pop_front();
      o = sample_outputs();
      check_output($sformatf("%s c%0d", name, k), 32'(o), 32'(e));
      check_count($sformatf("%s count c%0d", name, k));
      if (e.done) exp_cnt++;
      if (k == abort_at) begin
        #1 reset = 1'b1;
        #1;
        o = sample_outputs();
        check_output($sformatf("%s abort", name), 32'(o), 32'(0));
        exp_q.delete();
        exp_cnt = 0;
        @(negedge clk);
        reset       = 1'b0;
        instr_valid = 1'b0;
        #1;
        o = sample_outputs();
        e = '0;
        e.ready = 1'b1;
        check_output($sformatf("%s post_abort", name), 32'(o), 32'(e));
        check_count($sformatf("%s post_abort count", name));
      end
      k++;
    end
    instr_valid = 1'b0;
  endtask

  task automatic apply_reset();
    obs_t e;
    @(negedge clk);
    reset       = 1'b1;
    instr_valid = 1'b0;
    ext_valid   = 1'b0;
    exp_cnt     = 0;
    #1;
    check_output("reset_outputs", 32'(sample_outputs()), 32'(0));
    check_count("reset_count");
    @(negedge clk);
    reset = 1'b0;
    #1;
    e = '0;
    e.ready = 1'b1;
    check_output("idle_after_reset", 32'(sample_outputs()), 32'(e));
  endtask

  initial begin
    checks      = 0;
    failures    = 0;
    exp_cnt     = 0;
    reset       = 1'b1;
    instr       = '0;
    instr_valid = 1'b0;
    ext_valid   = 1'b0;
    apply_reset();

    apply_stimulus("add_r1_r2",   10'b01_10_001000, 0, -1);
    apply_stimulus("ld_r3_stall", 10'b11_00_000000, 3, -1);
    apply_stimulus("subi_r0_5",   10'b00_000101_11, 0, -1);
    apply_stimulus("illegal_c",   10'b00_00_110000, 0, -1);
    apply_stimulus("illegal_sfx", 10'b00_00_000010, 0, -1);
    apply_stimulus("cp_r2_r3",    10'b10_11_000100, 0, -1);
    apply_stimulus("xor_r3_r0",   10'b11_00_100000, 0, -1);
    apply_stimulus("asr_r2_r1",   10'b10_01_101100, 0, -1);
    apply_stimulus("inv_r1_r1",   10'b01_01_010000, 0, -1);
    apply_stimulus("addi_r2_63",  10'b10_111111_01, 0, -1);
    apply_stimulus("ld_r1_nowait",10'b01_00_000000, 0, -1);
    apply_stimulus("illegal_f",   10'b11_11_111100, 0, -1);
    apply_stimulus("abort_add",   10'b01_10_001000, 0, 2);
    apply_stimulus("cp_after",    10'b00_01_000100, 0, -1);

`ifdef PROC_SEQ_PERF_EN
    apply_reset();
    for (int i = 0; i < 5; i++) begin
      apply_stimulus($sformatf("cp_wrap%0d", i), 10'b01_10_000100, 0, -1);
    end
    @(negedge clk);
    #1;
    check_count("final_count");
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
